memory_board_gen: RTL and testbench

Upstream stage of the Memory Matrix guess path. On a start request it builds a random 4x4 board (16-bit tile mask) with a requested number of lit tiles, drawn from a free-running LFSR. It then presents the board for a fixed display window so the player can memorise it, and finally holds the board stable with `ready` asserted. The guess-checking stage samples `board` while `ready` is high and compares player guesses against it.

---
 rtl/memory_board_gen.sv | 83 ++++++++
 tb/tb_memory_board_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_board_gen.sv
// Memory Matrix board generator: builds a random 4x4 tile mask with a clamped
// number of lit tiles, shows it for SHOW_CYCLES, then holds it for guessing.
module memory_board_gen #(
  parameter int          SHOW_CYCLES = 100_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  num_tiles,
  output logic [15:0] board,
  output logic        show,
  output logic        ready,
  output logic        busy
);

  localparam int TW = $clog2(SHOW_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GEN, SHOW, READY} state_t;

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic [15:0]     r_board;
  logic [3:0]      r_count;
  logic [3:0]      r_target;
  logic [TW-1:0]   r_timer;

  logic [15:0]     w_lfsr_nxt;
  logic [3:0]      w_idx;
  logic [3:0]      w_target;

  // Galois LFSR, taps x^16+x^14+x^13+x^11+1; runs in every state so start timing seeds the board
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_idx      = r_lfsr[3:0];
  assign w_target   = (num_tiles == 5'd0)  ? 4'd1  :
                      (num_tiles >= 5'd16) ? 4'd15 : num_tiles[3:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_lfsr   <= LFSR_SEED;
      r_board  <= '0;
      r_count  <= '0;
      r_target <= '0;
      r_timer  <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      case (r_state)
        IDLE, READY: begin
          if (start) begin
            r_target <= w_target;
            r_board  <= '0;
            r_count  <= '0;
            r_state  <= GEN;
          end
        end
        GEN: begin
          // duplicate nibbles leave the board and count untouched, costing one cycle
          if (!r_board[w_idx]) begin
            r_board[w_idx] <= 1'b1;
            r_count        <= r_count + 4'd1;
            if (r_count + 4'd1 == r_target) begin
              r_state <= SHOW;
              r_timer <= TW'(SHOW_CYCLES - 1);
            end
          end
        end
        SHOW: begin
          if (r_timer == '0) r_state <= READY;
          else               r_timer <= r_timer - TW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign show  = (r_state == SHOW);
  assign ready = (r_state == READY);
  assign busy  = (r_state == GEN) || (r_state == SHOW);
  // partial boards stay hidden while GEN is filling them in
  assign board = (show || ready) ? r_board : 16'h0000;

endmodule

// File: tb/tb_memory_board_gen.sv
// Scoreboard bench for memory_board_gen: a reference LFSR tracks the DUT so each
// accepted start pushes the expected board and GEN length, popped on first show.
module tb_memory_board_gen;

  localparam int          SC   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  num_tiles = 5'd0;
  logic [15:0] board;
  logic        show, ready, busy;

  typedef struct {
    logic [15:0] b;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  memory_board_gen #(.SHOW_CYCLES(SC), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .board(board), .show(show), .ready(ready), .busy(busy)
  );

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) m_lfsr <= !reset ? SEED : step(m_lfsr);

  function automatic void predict(input logic [15:0] l0, input int tgt,
                                  output logic [15:0] b, output int len);
    logic [15:0] l;
    int cnt;
    l = l0; b = '0; cnt = 0; len = 0;
    while (cnt < tgt && len < 70000) begin
      len++;
      if (!b[l[3:0]]) begin b[l[3:0]] = 1'b1; cnt++; end
      l = step(l);
    end
  endfunction

  // called at a negedge while the DUT sits in IDLE/READY; returns at the first GEN negedge
  task automatic kick(input logic [4:0] nt);
    exp_t e;
    int tgt;
    tgt = (nt == 5'd0) ? 1 : (nt > 5'd15) ? 15 : int'(nt);
    predict(step(m_lfsr), tgt, e.b, e.len);
    sb.push_back(e);
    num_tiles = nt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_show(inout int len, output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (show) begin to = 1'b0; break; end
      if (busy) len++;
      @(negedge clk);
    end
  endtask

  task automatic measure_show(output int n);
    n = 0;
    while (show && n < 50) begin n++; @(negedge clk); end
  endtask

  task automatic run_board(input logic [4:0] nt, output logic [15:0] ob, output int olen,
                           output exp_t e, output bit to);
    olen = 0;
    kick(nt);
    wait_show(olen, to);
    e = sb.pop_front();
    ob = board;
  endtask

  task automatic test_reset();
    int len, n;
    bit to;
    exp_t e;
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (board !== 16'h0) begin n_fail++; $display("FAIL reset_board got %h want 0000", board); end
    n_tests++; if (show !== 1'b0)   begin n_fail++; $display("FAIL reset_show got %b want 0", show); end
    n_tests++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    // release reset and start together: GEN sees lfsr = step(ACE1) = E270, nibble 0
    reset = 1'b1;
    kick(5'd1);
    len = 0;
    wait_show(len, to);
    e = sb.pop_front();
    n_tests++; if (to || board !== 16'h0001) begin n_fail++; $display("FAIL seed_board got %h want 0001 timeout=%0d", board, to); end
    n_tests++; if (len !== 1) begin n_fail++; $display("FAIL seed_gen_len got %0d want 1", len); end
    n_tests++; if (e.b !== 16'h0001) begin n_fail++; $display("FAIL seed_model got %h want 0001", e.b); end
    measure_show(n);
  endtask

  task automatic test_basic();
    logic [15:0] ob;
    int olen, n;
    bit to, bad;
    exp_t e;
    @(negedge clk);
    run_board(5'd5, ob, olen, e, to);
    n_tests++; if (to || $countones(ob) != 5) begin n_fail++; $display("FAIL basic_popcount got %0d want 5 timeout=%0d", $countones(ob), to); end
    n_tests++; if (ob !== e.b) begin n_fail++; $display("FAIL basic_board got %h want %h", ob, e.b); end
    n_tests++; if (olen != e.len) begin n_fail++; $display("FAIL basic_gen_len got %0d want %0d", olen, e.len); end
    measure_show(n);
    n_tests++; if (n != SC) begin n_fail++; $display("FAIL basic_show_len got %0d want %0d", n, SC); end
    n_tests++; if (ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_ready got ready=%b busy=%b want 1/0", ready, busy); end
    bad = 1'b0;
    repeat (100) begin
      if (board !== e.b || ready !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL basic_hold got board=%h want %h held", board, e.b); end
  endtask

  task automatic test_clamp();
    logic [4:0] nts[3];
    int         tg[3];
    logic [15:0] ob;
    int olen, n;
    bit to;
    exp_t e;
    nts = '{5'd0, 5'd20, 5'd15};
    tg  = '{1, 15, 15};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      run_board(nts[k], ob, olen, e, to);
      n_tests++; if (to || $countones(ob) != tg[k]) begin n_fail++; $display("FAIL clamp_pop nt=%0d got %0d want %0d", nts[k], $countones(ob), tg[k]); end
      n_tests++; if (ob !== e.b || olen > 2000) begin n_fail++; $display("FAIL clamp_board nt=%0d got %h/%0d want %h/%0d", nts[k], ob, olen, e.b, e.len); end
      measure_show(n);
    end
  endtask

  task automatic test_ignore();
    int len, n;
    bit to;
    exp_t e;
    @(negedge clk);
    kick(5'd10);
    len = 0;
    if (busy && !show) len++;
    @(negedge clk);
    if (busy && !show) len++;
    num_tiles = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_show(len, to);
    e = sb.pop_front();
    n_tests++; if (to || board !== e.b) begin n_fail++; $display("FAIL ignore_gen_board got %h want %h", board, e.b); end
    n_tests++; if (len != e.len) begin n_fail++; $display("FAIL ignore_gen_len got %0d want %0d", len, e.len); end
    n = 0;
    while (show && n < 50) begin
      n++;
      start = (n == 2);
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++; if (n != SC) begin n_fail++; $display("FAIL ignore_show_len got %0d want %0d", n, SC); end
    n_tests++; if (ready !== 1'b1 || board !== e.b) begin n_fail++; $display("FAIL ignore_ready got ready=%b board=%h want 1/%h", ready, board, e.b); end
  endtask

  task automatic test_restart_ready();
    int len, n;
    bit to;
    exp_t e;
    @(negedge clk);
    kick(5'd7);
    n_tests++; if (ready !== 1'b0 || board !== 16'h0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL restart_gen got ready=%b board=%h busy=%b want 0/0000/1", ready, board, busy); end
    len = 0;
    wait_show(len, to);
    e = sb.pop_front();
    n_tests++; if (to || $countones(board) != 7 || board !== e.b) begin n_fail++; $display("FAIL restart_board got %h want %h", board, e.b); end
    measure_show(n);
  endtask

  task automatic seq_after_reset(output logic [15:0] b, output bit to);
    int len;
    exp_t e;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    kick(5'd6);
    len = 0;
    wait_show(len, to);
    e = sb.pop_front();
    b = board;
    n_tests++; if (to || b !== e.b) begin n_fail++; $display("FAIL reseq_board got %h want %h", b, e.b); end
  endtask

  task automatic test_reset_mid_show();
    logic [15:0] b1, b2;
    bit to;
    int n;
    seq_after_reset(b1, to);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (board !== 16'h0 || show || ready || busy)
      begin n_fail++; $display("FAIL midshow_reset got board=%h show=%b ready=%b busy=%b want all 0", board, show, ready, busy); end
    seq_after_reset(b2, to);
    n_tests++; if (b2 !== b1) begin n_fail++; $display("FAIL determinism got %h want %h", b2, b1); end
    measure_show(n);
  endtask

  task automatic test_duplicate();
    logic [15:0] pb;
    int plen, len, n;
    bit found, to;
    exp_t e;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      predict(step(m_lfsr), 8, pb, plen);
      if (plen > 8) begin found = 1'b1; break; end
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL dup_search got none want a duplicate timing"); end
    kick(5'd8);
    len = 0;
    wait_show(len, to);
    e = sb.pop_front();
    n_tests++; if (to || $countones(board) != 8 || board !== e.b) begin n_fail++; $display("FAIL dup_board got %h want %h", board, e.b); end
    n_tests++; if (len != e.len || (found && len <= 8)) begin n_fail++; $display("FAIL dup_gen_len got %0d want %0d", len, e.len); end
    measure_show(n);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_ignore();
    test_restart_ready();
    test_reset_mid_show();
    test_duplicate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
